uart_rx: RTL and testbench

Receive end of the team's 8N1 UART link, and the counterpart of the existing req/busy transmitter.
- Samples the asynchronous serial line on a 16x oversampling pulse from the shared baud generator.
- Validates the start bit and majority-votes each bit at mid-bit.
- Presents each received byte on a valid/ack handshake to the downstream consumer, e.g. the LED/command decoder.
- Bit order defaults to MSB first, to match the transmitter.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled, 3-tap majority vote, valid/ack byte output.
// Define UART_RX_BREAK_DET_EN to add the brk output for all-zero frames with a low stop bit.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_pulse,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 brk,
`endif
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           vote_q;
  logic                 vote;
  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 stop_tick, deliver, bad_stop, ferr_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                 brk_d;
`endif

  assign rx_s = sync_q[1];
  assign vote = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);

  // State register plus synchronizer, vote taps and the output handshake registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      sync_q    <= 2'b11;
      vote_q    <= 3'b111;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk       <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], rx};
      if (os_pulse) vote_q <= {vote_q[1:0], rx_s};
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;

      frame_err <= ferr_d;
`ifdef UART_RX_BREAK_DET_EN
      brk       <= brk_d;
`endif
      // A coincident ack frees the holding register, so the new byte is not an overrun.
      overrun <= deliver & rx_valid & ~rx_ack;
      if (deliver && (!rx_valid || rx_ack)) begin
        rx_data  <= shreg_q;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Next-state logic: everything advances only on an oversample tick.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves a latch behind.
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (os_pulse) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            if (vote) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == TICK_LAST) begin
            shreg_d = MSB_FIRST ? {shreg_q[DATA_BITS-2:0], vote}
                                : {vote, shreg_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
            tick_d  = '0;
            if (bit_q == BIT_LAST) state_d = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_q == TICK_LAST) begin
            state_d = vote ? IDLE : WAIT_IDLE;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        WAIT_IDLE: begin
          // Hold here until the line is seen high so a stuck-low line cannot retrigger.
          if (vote) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode of the stop-bit decision tick.
  always_comb begin
    stop_tick = os_pulse && (state_q == STOP) && (tick_q == TICK_LAST);
    deliver   = stop_tick && vote;
    bad_stop  = stop_tick && !vote;
    busy      = (state_q != IDLE);
`ifdef UART_RX_BREAK_DET_EN
    brk_d     = bad_stop && (shreg_q == '0);
    ferr_d    = bad_stop && !brk_d;
`else
    ferr_d    = bad_stop;
`endif
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a byte scoreboard and immediate-assertion checks.
// Covers MSB/LSB order, false start, framing error, overrun, reset mid-frame and break.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       os_pulse = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic       rx_l = 1'b1;
  logic       ack_l = 1'b0;
  logic [7:0] rx_data, rx_data_l;
  logic       rx_valid, frame_err, overrun, busy;
  logic       rx_valid_l, frame_err_l, overrun_l, busy_l;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk, brk_l;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_n = 0, ovr_n = 0, brk_n = 0, busy_clks = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .os_pulse(os_pulse), .rx(rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun),
`ifdef UART_RX_BREAK_DET_EN
    .brk(brk),
`endif
    .busy(busy)
  );

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .os_pulse(os_pulse), .rx(rx_l), .rx_ack(ack_l),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l), .frame_err(frame_err_l), .overrun(overrun_l),
`ifdef UART_RX_BREAK_DET_EN
    .brk(brk_l),
`endif
    .busy(busy_l)
  );

  initial forever #5 clk = ~clk;

  // One-clk oversample tick every 4 clocks, changed just after the rising edge.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #2;
      os_pulse = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // Pulse and activity counters; the stimulus compares deltas of these.
  always @(negedge clk) begin
    if (frame_err) ferr_n++;
    if (overrun) ovr_n++;
    if (busy) busy_clks++;
`ifdef UART_RX_BREAK_DET_EN
    if (brk) brk_n++;
`endif
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no completion, required finish before 400000 ns");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (os_pulse) k++;
    end
  endtask

  task automatic set_line(input bit to_lsb, input logic v);
    if (to_lsb) rx_l = v;
    else rx = v;
  endtask

  // Start bit plus data bits (seq[7] first on the line); returns just after the stop bit starts.
  task automatic send_head(input logic [7:0] seq, input bit to_lsb, input logic stop_lvl);
    wait_ticks(1);
    @(negedge clk);
    set_line(to_lsb, 1'b0);
    for (int k = 7; k >= 0; k--) begin
      wait_ticks(16);
      @(negedge clk);
      set_line(to_lsb, seq[k]);
    end
    wait_ticks(16);
    @(negedge clk);
    set_line(to_lsb, stop_lvl);
  endtask

  task automatic send_frame(input logic [7:0] seq, input bit to_lsb);
    send_head(seq, to_lsb, 1'b1);
    wait_ticks(16);
    @(negedge clk);
  endtask

  task automatic ack_byte();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] e_byte;
    int f0, o0, b0, bz0, w;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_busy", busy, 1'b0);

    // 0xA5, exact delivery cycle relative to the stop mid-bit tick
    exp_q.push_back(8'hA5);
    f0 = ferr_n;
    o0 = ovr_n;
    send_head(8'hA5, 1'b0, 1'b1);
    wait_ticks(8);
    @(negedge clk);
    check("a5_valid_before_stop_tick", rx_valid, 1'b0);
    wait_ticks(1);
    @(negedge clk);
    check("a5_valid_after_stop_tick", rx_valid, 1'b1);
    e_byte = exp_q.pop_front();
    check("a5_data", rx_data, e_byte);
    wait_ticks(7);
    @(negedge clk);
    check("a5_no_frame_err", ferr_n - f0, 0);
    check("a5_no_overrun", ovr_n - o0, 0);
    ack_byte();
    check("a5_ack_clears_valid", rx_valid, 1'b0);

    // LSB-first receiver: first data bit on the line lands in rx_data[0]
    exp_q.push_back(8'h01);
    send_frame(8'b1000_0000, 1'b1);
    check("lsb_valid", rx_valid_l, 1'b1);
    e_byte = exp_q.pop_front();
    check("lsb_data", rx_data_l, e_byte);

    // 4-tick low glitch on an idle line is rejected as a false start
    f0 = ferr_n;
    bz0 = busy_clks;
    wait_ticks(1);
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(16);
    @(negedge clk);
    check("glitch_busy_seen", (busy_clks - bz0) > 0, 1'b1);
    check("glitch_busy_le_8_ticks", (busy_clks - bz0) <= 32, 1'b1);
    check("glitch_no_valid", rx_valid, 1'b0);
    check("glitch_no_frame_err", ferr_n - f0, 0);
    check("glitch_idle", busy, 1'b0);

    // 0x3C with stop held low for two bit periods, then a clean 0x55
    f0 = ferr_n;
    send_head(8'h3C, 1'b0, 1'b0);
    wait_ticks(32);
    @(negedge clk);
    check("ferr_waits_for_high_line", busy, 1'b1);
    rx = 1'b1;
    wait_ticks(16);
    @(negedge clk);
    check("ferr_single_pulse", ferr_n - f0, 1);
    check("ferr_no_valid", rx_valid, 1'b0);
    check("ferr_back_idle", busy, 1'b0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0);
    check("after_ferr_valid", rx_valid, 1'b1);
    e_byte = exp_q.pop_front();
    check("after_ferr_data", rx_data, e_byte);
    check("after_ferr_no_new_ferr", ferr_n - f0, 1);
    ack_byte();
    check("after_ferr_ack", rx_valid, 1'b0);

    // Overrun: 0x22 arrives while 0x11 is still held
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0);
    o0 = ovr_n;
    send_frame(8'h22, 1'b0);
    e_byte = exp_q.pop_front();
    check("overrun_keeps_old_data", rx_data, e_byte);
    check("overrun_valid_held", rx_valid, 1'b1);
    check("overrun_single_pulse", ovr_n - o0, 1);
    ack_byte();
    check("overrun_ack", rx_valid, 1'b0);

    // Ack on the exact delivery clock of the second byte
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0);
    e_byte = exp_q.pop_front();
    check("coinc_first_data", rx_data, e_byte);
    exp_q.push_back(8'h22);
    o0 = ovr_n;
    send_head(8'h22, 1'b0, 1'b1);
    wait_ticks(8);
    @(negedge clk);
    w = 0;
    while (!os_pulse && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("coinc_tick_found", os_pulse, 1'b1);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("coinc_valid_stays", rx_valid, 1'b1);
    e_byte = exp_q.pop_front();
    check("coinc_new_data", rx_data, e_byte);
    wait_ticks(8);
    @(negedge clk);
    check("coinc_no_overrun", ovr_n - o0, 0);

    // Reset in the middle of data bit 4 of 0xF0 (0x22 still held), then a clean 0x0F
    f0 = ferr_n;
    wait_ticks(1);
    @(negedge clk);
    rx = 1'b0;
    for (int k = 7; k >= 3; k--) begin
      wait_ticks(16);
      @(negedge clk);
      rx = k[0] ? 1'b1 : 1'b1;
      rx = (k >= 4);
    end
    wait_ticks(8);
    @(negedge clk);
    check("midframe_busy", busy, 1'b1);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_busy", busy, 1'b0);
    wait_ticks(4);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b0);
    check("post_rst_valid", rx_valid, 1'b1);
    e_byte = exp_q.pop_front();
    check("post_rst_data", rx_data, e_byte);
    check("post_rst_no_ferr", ferr_n - f0, 0);
    ack_byte();
    check("post_rst_ack", rx_valid, 1'b0);

    // Line held low for 12 bit periods
    f0 = ferr_n;
    b0 = brk_n;
    wait_ticks(1);
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(16 * 12);
    @(negedge clk);
    check("break_still_busy", busy, 1'b1);
    rx = 1'b1;
    wait_ticks(16);
    @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
    check("break_brk_pulse", brk_n - b0, 1);
    check("break_no_frame_err", ferr_n - f0, 0);
`else
    check("break_as_frame_err", ferr_n - f0, 1);
    check("break_no_brk", brk_n - b0, 0);
`endif
    check("break_no_valid", rx_valid, 1'b0);
    check("break_back_idle", busy, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
